// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target at 7-bit address SLAVE_ADDR fronting a byte
// register file (MPU-6050 style: auto-increment pointer, WHO_AM_I at 0x75).
// SCL/SDA are oversampled on clk; the block only ever pulls SDA low.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter behind each synchronizer (rejects 1-clk pulses, +2 clk latency).
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter int         REG_AW     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCL,
  inout  wire               SDA,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              wr_strobe,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int         REG_N   = 2 ** REG_AW;
  localparam logic [8:0] REG_LIM = 9'(REG_N);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK_WAIT, ST_IGNORE
  } state_t;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Pointer values at or above the register count are valid on the bus but unbacked.
  function automatic logic in_range(input logic [7:0] p);
    return ({1'b0, p} < REG_LIM);
  endfunction

  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_s, sda_s;
  logic       scl_q_r, sda_q_r;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] rx_byte_s, rd_byte_s;
  logic       i2c_we_s;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic [6:0] tx_r;
  logic [7:0] ptr_r;
  logic       rw_r;
  logic       rack_ok_r;
  logic       sda_oe_r;
  logic [7:0] regs_r [REG_N];

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], SCL};
      sda_sync_r <= {sda_sync_r[0], SDA};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r, sda_hist_r;
  logic       scl_flt_r, sda_flt_r;

  // Majority over the current and two previous samples; a lone sample cannot flip the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_flt_r  <= 1'b1;
      sda_flt_r  <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
      scl_flt_r  <= maj3(scl_sync_r[1], scl_hist_r[0], scl_hist_r[1]);
      sda_flt_r  <= maj3(sda_sync_r[1], sda_hist_r[0], sda_hist_r[1]);
    end
  end

  assign scl_s = scl_flt_r;
  assign sda_s = sda_flt_r;
`else
  assign scl_s = scl_sync_r[1];
  assign sda_s = sda_sync_r[1];
`endif

  // Previous bus levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q_r <= 1'b1;
      sda_q_r <= 1'b1;
    end else begin
      scl_q_r <= scl_s;
      sda_q_r <= sda_s;
    end
  end

  // Bus event decode, received byte, read byte source and register write request.
  always_comb begin
    scl_rise_s = scl_s & ~scl_q_r;
    scl_fall_s = ~scl_s & scl_q_r;
    start_s    = scl_s & scl_q_r & sda_q_r & ~sda_s;
    stop_s     = scl_s & scl_q_r & ~sda_q_r & sda_s;
    rx_byte_s  = {shift_r, sda_s};
    if (in_range(ptr_r)) begin
      rd_byte_s = regs_r[ptr_r[REG_AW-1:0]];
    end else begin
      rd_byte_s = 8'h00;
    end
    if ((state_r == ST_WDATA) && scl_rise_s && (bit_cnt_r == 4'd7) && in_range(ptr_r)) begin
      i2c_we_s = 1'b1;
    end else begin
      i2c_we_s = 1'b0;
    end
  end

  // Register file; the host write is applied last so it wins a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_r[i] <= (i == 32'h75) ? {1'b0, SLAVE_ADDR} : 8'h00;
      end
    end else begin
      if (i2c_we_s) begin
        regs_r[ptr_r[REG_AW-1:0]] <= rx_byte_s;
      end
      if (host_we) begin
        regs_r[host_addr] <= host_wdata;
      end
    end
  end

  // Protocol FSM. In the ACK states sda_oe_r doubles as the phase flag:
  // the first SCL fall starts the ACK, the second one ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 7'd0;
      tx_r      <= 7'd0;
      ptr_r     <= 8'd0;
      rw_r      <= 1'b0;
      rack_ok_r <= 1'b0;
      sda_oe_r  <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_s) begin
        state_r  <= ST_IDLE;
        sda_oe_r <= 1'b0;
        busy     <= 1'b0;
      end else if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_IGNORE: begin
            sda_oe_r <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s[6:0];
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                  state_r <= ST_ADDR_ACK;
                  rw_r    <= rx_byte_s[0];
                  busy    <= 1'b1;
                end else begin
                  state_r <= ST_IGNORE;
                  busy    <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else if (rw_r) begin
                tx_r      <= rd_byte_s[6:0];
                sda_oe_r  <= ~rd_byte_s[7];
                bit_cnt_r <= 4'd0;
                state_r   <= ST_RDATA;
              end else begin
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_REG;
              end
            end
          end
          ST_REG: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s[6:0];
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                ptr_r   <= rx_byte_s;
                state_r <= ST_REG_ACK;
              end
            end
          end
          ST_REG_ACK: begin
            if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else begin
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s[6:0];
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                wr_strobe <= 1'b1;
                wr_addr   <= ptr_r;
                wr_data   <= rx_byte_s;
                state_r   <= ST_WDATA_ACK;
              end
            end
          end
          ST_WDATA_ACK: begin
            if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else begin
                sda_oe_r  <= 1'b0;
                ptr_r     <= ptr_r + 8'd1;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r  <= 1'b0;
                rack_ok_r <= 1'b0;
                state_r   <= ST_RACK_WAIT;
              end else begin
                sda_oe_r <= ~tx_r[6];
                tx_r     <= {tx_r[5:0], 1'b0};
              end
            end
          end
          ST_RACK_WAIT: begin
            if (scl_rise_s) begin
              if (sda_s) begin
                state_r <= ST_IGNORE;
                busy    <= 1'b0;
              end else begin
                ptr_r     <= ptr_r + 8'd1;
                rack_ok_r <= 1'b1;
              end
            end else if (scl_fall_s && rack_ok_r) begin
              tx_r      <= rd_byte_s[6:0];
              sda_oe_r  <= ~rd_byte_s[7];
              bit_cnt_r <= 4'd0;
              state_r   <= ST_RDATA;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SDA = sda_oe_r ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) that answers the I2C master driver at 7-bit address SLAVE_ADDR and exposes an MPU-6050-style byte register file. It serves as the bus-side model for bench and loopback builds, letting the master's init and read sequence run end to end. It decodes START/STOP, address and register-pointer bytes, and handles writes and auto-incrementing reads. A host port lets a sensor model update register contents.

## Interface
- SLAVE_ADDR, 7'h68, 7-bit bus address the block acknowledges.
- REG_AW, 7, register-file address width; 2**REG_AW byte registers.
- clk  in  1  system clock; all logic is synchronous to it, SCL is sampled.
- rst_n  in  1  asynchronous active-low reset.
- SCL  in  1  bus clock from the master (open drain, pulled up externally).
- SDA  inout  1  bus data; the block only drives 0 (`sda_oe ? 1'b0 : 1'bz`).
- host_we  in  1  host write strobe.
- host_addr  in  REG_AW  host write address.
- host_wdata  in  8  host write data.
- wr_strobe  out  1  one-cycle pulse per register byte written over I2C.
- wr_addr  out  8  register pointer of that write.
- wr_data  out  8  byte written.
- busy  out  1  high from an address-matched START until STOP or NACK release.

## Operation
- Input path: 2-flop synchronizers on SCL and SDA, then edge detect. START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE.
- IDLE: START leads to ADDR with bit_cnt=0.
- ADDR: shift 8 bits on SCL rising edges, MSB first.
  - If addr[7:1]==SLAVE_ADDR, go to ADDR_ACK.
  - Otherwise go to IGNORE, which does not drive SDA until the next START or STOP.
- ADDR_ACK: drive SDA low for the 9th clock.
  - With R/W=0, next state is REG.
  - With R/W=1, load shift register from regs[ptr] and go to RDATA.
- REG: receive 8 bits into ptr, ACK, then WDATA.
- WDATA: receive a byte. If ptr < 2**REG_AW, write it to regs[ptr]. Pulse wr_strobe with the old ptr in every case. ACK, then ptr = ptr+1 (8-bit, wraps 0xFF to 0x00) and stay in WDATA.
- RDATA: present MSB first. Change SDA only after an SCL falling edge. Registers with ptr ≥ 2**REG_AW read 8'h00.
- RACK_WAIT: sample the master's bit on the 9th SCL rising edge.
  - ACK(0): ptr+1, reload the shift register, back to RDATA.
  - NACK(1): release SDA and go to IGNORE.
- Repeated START in any state goes to ADDR. ptr is kept, so "write reg addr, Sr, read" works.
- STOP in any state goes to IDLE, releases SDA and clears busy.
- Host write and I2C write to the same register in the same clk: the host write wins and wr_strobe still pulses.
- Reset: regs all 8'h00 except reg 8'h75 (WHO_AM_I) = SLAVE_ADDR zero-extended, when in range. ptr=0, state IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
- Reset mid-transfer releases SDA immediately (asynchronous). Bus activity until the next START is ignored.

## Timing
- clk must be ≥ 8× SCL frequency (≥ 12× with the filter).
- SCL/SDA sampling latency is 2 clk, or 4 clk with the filter.
- sda_oe changes 1 clk after the detected SCL falling edge, so SDA is stable well before the next rising edge.
- wr_strobe asserts 1 clk after the 8th data-bit rising edge is detected.
- The read byte is snapshot at load time. Host writes during byte shift-out affect the next byte only.
- busy rises the cycle ADDR_ACK is entered.

## Configuration
- I2C_TARGET_GLITCH_FILTER_EN defined: a 3-sample majority filter follows each synchronizer. Pulses ≤1 clk on SCL/SDA are rejected and latency is +2 clk.
- Not defined: synchronizer output is used directly, and single-clk glitches are seen as edges.

## Test plan
- Write 0x6B←0x00 at address 0x68: 3 ACKs, wr_strobe once with wr_addr=0x6B and wr_data=0x00, regs[0x6B]=0x00.
- Host writes 0x43=0x12, 0x44=0x34. Master writes ptr 0x43, sends Sr, reads 2 bytes with ACK then NACK: returns 0x12, 0x34; SDA released after NACK; busy low after STOP.
- Address 0x69: no ACK on 9th clock, SDA never driven, busy stays 0, no wr_strobe.
- Burst write from ptr 0xFE of 3 bytes: wr_addr sequence 0xFE, 0xFF, 0x00. Out-of-range 0xFE/0xFF are ACKed but not stored; regs[0x00] is updated.
- rst_n low during RDATA with SDA driven low: SDA released the same cycle. After reset, a read of 0x75 returns 0x68.
- With I2C_TARGET_GLITCH_FILTER_EN defined, a 1-clk SCL low glitch mid-byte causes no bit shift and the transfer completes correctly. Without the macro, the same stimulus misaligns the byte.
